// File: rtl/nco_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_pkg
// Description : Shared types, mode constants and clamped arithmetic helpers
//               for the NCO linear-sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sweep_state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    // Helpers work on a generic width; callers zero-extend and truncate.
    localparam int unsigned HELPER_W = 64;

    // min(a + b, hi), with the carry-out kept so a wrap clamps to hi.
    function automatic logic [HELPER_W-1:0] clamp_add(
        input logic [HELPER_W-1:0] a,
        input logic [HELPER_W-1:0] b,
        input logic [HELPER_W-1:0] hi
    );
        logic [HELPER_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, hi}) ? hi : sum[HELPER_W-1:0];
    endfunction

    // max(a - b, lo), with the borrow kept so an underflow clamps to lo.
    function automatic logic [HELPER_W-1:0] clamp_sub(
        input logic [HELPER_W-1:0] a,
        input logic [HELPER_W-1:0] b,
        input logic [HELPER_W-1:0] lo
    );
        logic [HELPER_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return (diff[HELPER_W] || (diff[HELPER_W-1:0] < lo)) ? lo : diff[HELPER_W-1:0];
    endfunction

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_SINGLE : m;
    endfunction

endpackage : nco_sweep_pkg
`default_nettype wire

// File: rtl/nco_sweep_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_dwell_cnt
// Description : Reloadable dwell down-counter advanced by clken; flags expiry
//               when it sits at zero on an enabled sample.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_dwell_cnt #(
    parameter int unsigned DWW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_clken,
    input  logic           i_active,
    input  logic           i_load,
    input  logic [DWW-1:0] i_load_val,
    output logic           o_expire
);

    logic [DWW-1:0] r_cnt;

    assign o_expire = i_active && i_clken && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_active && i_clken && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DWW'(1);
        end
    end

endmodule : nco_sweep_dwell_cnt
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Linear chirp controller driving NCO phase increment and phase
//               offset; single, sawtooth and triangle sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int unsigned APR  = 32,
    parameter int unsigned APRP = 16,
    parameter int unsigned DWW  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clken,
    input  logic            start,
    input  logic            abort,
    input  logic [APR-1:0]  cfg_start_inc,
    input  logic [APR-1:0]  cfg_stop_inc,
    input  logic [APR-1:0]  cfg_step,
    input  logic [DWW-1:0]  cfg_dwell,
    input  logic [1:0]      cfg_mode,
    input  logic [APRP-1:0] cfg_phase,
    output logic [APR-1:0]  phi_inc_o,
    output logic [APRP-1:0] phase_mod_o,
    output logic            busy,
    output logic            step_strobe,
    output logic            sweep_done,
    output logic            cfg_err
);

    sweep_state_t    r_state;
    sweep_state_t    w_state_nxt;

    logic [APR-1:0]  r_start;
    logic [APR-1:0]  r_stop;
    logic [APR-1:0]  r_step;
    logic [DWW-1:0]  r_dwell_m1;
    logic [1:0]      r_mode;

    logic [APR-1:0]  r_phi;
    logic [APRP-1:0] r_phase;
    logic            r_busy;
    logic            r_strobe;
    logic            r_done;
    logic            r_err;

    logic [APR-1:0]  w_phi_nxt;
    logic [APRP-1:0] w_phase_nxt;
    logic            w_busy_nxt;
    logic            w_strobe_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_accept;
    logic            w_cnt_load;
    logic [DWW-1:0]  w_cnt_val;

    logic            w_expire;
    logic            w_cfg_bad;
    logic [DWW-1:0]  w_cfg_dwell_m1;
    logic [APR-1:0]  w_phi_up;
    logic [APR-1:0]  w_phi_dn;

    assign w_cfg_bad = (cfg_start_inc > cfg_stop_inc) ||
                       ((cfg_step == '0) && (cfg_start_inc != cfg_stop_inc));

    assign w_cfg_dwell_m1 = (cfg_dwell == '0) ? '0 : (cfg_dwell - DWW'(1));

    // Clamped neighbours of the current increment; also give the turn-around
    // values because phi equals stop (or start) at those points.
    assign w_phi_up = APR'(clamp_add(HELPER_W'(r_phi), HELPER_W'(r_step), HELPER_W'(r_stop)));
    assign w_phi_dn = APR'(clamp_sub(HELPER_W'(r_phi), HELPER_W'(r_step), HELPER_W'(r_start)));

    nco_sweep_dwell_cnt #(
        .DWW (DWW)
    ) u_dwell_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clken    (clken),
        .i_active   (r_busy),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_phi_nxt    = r_phi;
        w_phase_nxt  = r_phase;
        w_busy_nxt   = r_busy;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_accept     = 1'b0;
        w_cnt_load   = w_expire;
        w_cnt_val    = r_dwell_m1;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_bad) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_accept     = 1'b1;
                            w_cnt_load   = 1'b1;
                            w_cnt_val    = w_cfg_dwell_m1;
                            w_phi_nxt    = cfg_start_inc;
                            w_phase_nxt  = cfg_phase;
                            w_busy_nxt   = 1'b1;
                            w_strobe_nxt = 1'b1;
                            w_state_nxt  = ST_UP;
                        end
                    end
                end
                ST_UP: begin
                    if (w_expire) begin
                        if (r_phi != r_stop) begin
                            w_phi_nxt    = w_phi_up;
                            w_strobe_nxt = 1'b1;
                        end else if (r_mode == MODE_SAW) begin
                            w_phi_nxt    = r_start;
                            w_strobe_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                        end else if (r_mode == MODE_TRI) begin
                            w_phi_nxt    = w_phi_dn;
                            w_strobe_nxt = 1'b1;
                            // A degenerate start==stop sweep completes on every dwell.
                            w_done_nxt   = (r_start == r_stop);
                            w_state_nxt  = ST_DOWN;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DOWN: begin
                    if (w_expire) begin
                        w_strobe_nxt = 1'b1;
                        if (r_phi != r_start) begin
                            w_phi_nxt = w_phi_dn;
                        end else begin
                            w_phi_nxt   = w_phi_up;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_UP;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_phi    <= '0;
            r_phase  <= '0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phi    <= w_phi_nxt;
            r_phase  <= w_phase_nxt;
            r_busy   <= w_busy_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_start    <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_dwell_m1 <= '0;
            r_mode     <= MODE_SINGLE;
        end else if (w_accept) begin
            r_start    <= cfg_start_inc;
            r_stop     <= cfg_stop_inc;
            r_step     <= cfg_step;
            r_dwell_m1 <= w_cfg_dwell_m1;
            r_mode     <= norm_mode(cfg_mode);
        end
    end

    assign phi_inc_o   = r_phi;
    assign phase_mod_o = r_phase;
    assign busy        = r_busy;
    assign step_strobe = r_strobe;
    assign sweep_done  = r_done;
    assign cfg_err     = r_err;

endmodule : nco_sweep_ctrl
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_sweep_ctrl
// Description : Directed self-checking bench for the NCO sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

    localparam int unsigned APR  = 32;
    localparam int unsigned APRP = 16;
    localparam int unsigned DWW  = 16;

    logic            clk;
    logic            reset_n;
    logic            clken;
    logic            start;
    logic            abort;
    logic [APR-1:0]  cfg_start_inc;
    logic [APR-1:0]  cfg_stop_inc;
    logic [APR-1:0]  cfg_step;
    logic [DWW-1:0]  cfg_dwell;
    logic [1:0]      cfg_mode;
    logic [APRP-1:0] cfg_phase;
    logic [APR-1:0]  phi_inc_o;
    logic [APRP-1:0] phase_mod_o;
    logic            busy;
    logic            step_strobe;
    logic            sweep_done;
    logic            cfg_err;

    int n_cmp;
    int n_err;

    nco_sweep_ctrl #(
        .APR  (APR),
        .APRP (APRP),
        .DWW  (DWW)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .start         (start),
        .abort         (abort),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_mode      (cfg_mode),
        .cfg_phase     (cfg_phase),
        .phi_inc_o     (phi_inc_o),
        .phase_mod_o   (phase_mod_o),
        .busy          (busy),
        .step_strobe   (step_strobe),
        .sweep_done    (sweep_done),
        .cfg_err       (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [APR-1:0] s, input logic [APR-1:0] e,
                            input logic [APR-1:0] st, input logic [DWW-1:0] d,
                            input logic [1:0] m, input logic [APRP-1:0] ph);
        cfg_start_inc = s;
        cfg_stop_inc  = e;
        cfg_step      = st;
        cfg_dwell     = d;
        cfg_mode      = m;
        cfg_phase     = ph;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    logic [APR-1:0] exp_phi;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        clken = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc = '0;
        cfg_step = '0;
        cfg_dwell = '0;
        cfg_mode = 2'd0;
        cfg_phase = '0;
        tick();
        tick();
        check_val("rst_phi",   64'(phi_inc_o), 64'd0);
        check_val("rst_phase", 64'(phase_mod_o), 64'd0);
        check_val("rst_flags", 64'({busy, step_strobe, sweep_done, cfg_err}), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single sweep, dwell 2
        do_start(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 16'h1234);
        check_val("single_acc_phi",   64'(phi_inc_o), 64'd100);
        check_val("single_acc_phase", 64'(phase_mod_o), 64'h1234);
        check_val("single_acc_flags", 64'({busy, step_strobe, sweep_done}), 64'b110);
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_phi = (k >= 6) ? 32'd130 : 32'(100 + 10 * (k / 2));
            check_val($sformatf("single_phi_%0d", k), 64'(phi_inc_o), 64'(exp_phi));
            check_val($sformatf("single_strb_%0d", k), 64'(step_strobe), 64'((k % 2 == 0) && (k <= 6)));
            check_val($sformatf("single_done_%0d", k), 64'(sweep_done), 64'(k == 8));
            check_val($sformatf("single_busy_%0d", k), 64'(busy), 64'(k < 8));
        end

        // Clamp at stop
        do_start(32'd0, 32'd25, 32'd10, 16'd1, 2'd0, 16'h0);
        check_val("clamp_acc_phi", 64'(phi_inc_o), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            case (k)
                1:       exp_phi = 32'd10;
                2:       exp_phi = 32'd20;
                default: exp_phi = 32'd25;
            endcase
            check_val($sformatf("clamp_phi_%0d", k), 64'(phi_inc_o), 64'(exp_phi));
            check_val($sformatf("clamp_done_%0d", k), 64'(sweep_done), 64'(k == 4));
        end

        // Near full scale: carry-out must clamp, not wrap
        do_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'd0, 16'h0);
        check_val("fs_acc_phi", 64'(phi_inc_o), 64'hFFFF_FFF0);
        tick();
        check_val("fs_phi_1", 64'(phi_inc_o), 64'hFFFF_FFFF);
        tick();
        check_val("fs_phi_2", 64'(phi_inc_o), 64'hFFFF_FFFF);
        check_val("fs_done",  64'({sweep_done, busy}), 64'b10);

        // Triangle
        do_start(32'd10, 32'd30, 32'd10, 16'd1, 2'd2, 16'h0);
        check_val("tri_acc_phi", 64'(phi_inc_o), 64'd10);
        for (int k = 1; k <= 6; k++) begin
            tick();
            case (k)
                1, 3, 5: exp_phi = 32'd20;
                4:       exp_phi = 32'd10;
                default: exp_phi = 32'd30;
            endcase
            check_val($sformatf("tri_phi_%0d", k), 64'(phi_inc_o), 64'(exp_phi));
            check_val($sformatf("tri_done_%0d", k), 64'(sweep_done), 64'(k == 5));
            check_val($sformatf("tri_strb_%0d", k), 64'(step_strobe), 64'd1);
        end
        // Abort coinciding with an expiry at the top of the triangle
        do_abort();
        check_val("tri_abort_phi",   64'(phi_inc_o), 64'd30);
        check_val("tri_abort_flags", 64'({busy, step_strobe, sweep_done}), 64'b000);

        // Sawtooth with clken toggling
        do_start(32'd10, 32'd30, 32'd10, 16'd3, 2'd1, 16'h00AA);
        check_val("saw_acc_phi", 64'(phi_inc_o), 64'd10);
        for (int k = 1; k <= 18; k++) begin
            clken = (k % 2 == 1);
            tick();
            if (k < 5)       exp_phi = 32'd10;
            else if (k < 11) exp_phi = 32'd20;
            else if (k < 17) exp_phi = 32'd30;
            else             exp_phi = 32'd10;
            check_val($sformatf("saw_phi_%0d", k), 64'(phi_inc_o), 64'(exp_phi));
            check_val($sformatf("saw_strb_%0d", k), 64'(step_strobe), 64'(k == 5 || k == 11 || k == 17));
            check_val($sformatf("saw_done_%0d", k), 64'(sweep_done), 64'(k == 17));
        end
        clken = 1'b1;

        // Abort and start together: abort wins
        cfg_start_inc = 32'd500;
        cfg_stop_inc  = 32'd600;
        start = 1'b1;
        do_abort();
        start = 1'b0;
        check_val("ab_phi",   64'(phi_inc_o), 64'd10);
        check_val("ab_phase", 64'(phase_mod_o), 64'h00AA);
        check_val("ab_flags", 64'({busy, step_strobe, sweep_done, cfg_err}), 64'b0000);
        tick();
        check_val("ab_hold_phi", 64'(phi_inc_o), 64'd10);

        // Restart reloads cfg; dwell 0 acts as 1; mode 3 acts as single
        do_start(32'd500, 32'd600, 32'd50, 16'd0, 2'd3, 16'hBEEF);
        check_val("re_acc_phi",   64'(phi_inc_o), 64'd500);
        check_val("re_acc_phase", 64'(phase_mod_o), 64'hBEEF);
        tick();
        check_val("re_phi_1", 64'(phi_inc_o), 64'd550);
        tick();
        check_val("re_phi_2", 64'(phi_inc_o), 64'd600);
        tick();
        check_val("re_done", 64'({sweep_done, busy}), 64'b10);

        // Rejected starts
        do_start(32'd50, 32'd40, 32'd1, 16'd1, 2'd0, 16'h5555);
        check_val("err_pulse", 64'({cfg_err, busy, step_strobe}), 64'b100);
        check_val("err_phi",   64'(phi_inc_o), 64'd600);
        check_val("err_phase", 64'(phase_mod_o), 64'hBEEF);
        tick();
        check_val("err_clear", 64'(cfg_err), 64'd0);
        do_start(32'd7, 32'd9, 32'd0, 16'd1, 2'd0, 16'h0);
        check_val("err_step0", 64'({cfg_err, busy}), 64'b10);

        // step 0 with start == stop is legal
        do_start(32'd7, 32'd7, 32'd0, 16'd1, 2'd0, 16'h0);
        check_val("eq_acc", 64'({cfg_err, busy, 25'd0, phi_inc_o}), {2'b01, 25'd0, 32'd7, 5'd0} >> 5);
        tick();
        check_val("eq_done", 64'({sweep_done, busy}), 64'b10);
        check_val("eq_phi",  64'(phi_inc_o), 64'd7);

        // Start while busy is ignored; reset mid-sweep clears outputs
        do_start(32'd10, 32'd30, 32'd10, 16'd1, 2'd0, 16'h0077);
        cfg_start_inc = 32'd1000;
        cfg_stop_inc  = 32'd2000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_start_phi", 64'(phi_inc_o), 64'd20);
        check_val("busy_start_err", 64'(cfg_err), 64'd0);
        reset_n = 1'b0;
        tick();
        check_val("mid_rst_phi",   64'(phi_inc_o), 64'd0);
        check_val("mid_rst_phase", 64'(phase_mod_o), 64'd0);
        check_val("mid_rst_flags", 64'({busy, step_strobe, sweep_done, cfg_err}), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nco_sweep_ctrl
`default_nettype wire
